pmt_pulse_gen: RTL and testbench
================================

PMT_PULSE_GEN -- requirements
Module: pmt_pulse_gen

Interface
REQ-001 Parameter CH, default 4: number of independent PMT output channels, 1..16.
REQ-002 Parameter CNT_W, default 14: width of the period and high-time fields.
REQ-003 Parameter BURST_W, default 16: width of the burst-count field.
REQ-004 CLK  input  1  system clock, 100 MHz.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 cfg_we  input  1  config write strobe.
REQ-007 cfg_ch  input  clog2(CH), min 1  channel addressed by cfg_we.
REQ-008 cfg_period  input  CNT_W  period field P.
REQ-009 cfg_high  input  CNT_W  high-time field H.
REQ-010 cfg_burst  input  BURST_W  pulse count N; 0 = continuous.
REQ-011 start  input  CH  per-channel start request, level-sampled each cycle.
REQ-012 stop  input  CH  per-channel abort request.
REQ-013 PMT  output  CH  registered pulse outputs.
REQ-014 busy  output  CH  registered; 1 while the channel is not IDLE.
REQ-015 done  output  CH  registered one-cycle completion pulse.

Function
REQ-016 Each channel holds config registers P, H, N; cfg_we with cfg_ch=i loads them next cycle; cfg_ch >= CH is ignored.
REQ-017 Config writes are accepted in any state; a running channel uses the active copy latched at start, so a write takes effect on the next start.
REQ-018 Per-channel FSM states are IDLE, HIGH and LOW.
REQ-019 IDLE with start[i]=1 and stop[i]=0 at edge t: latch active copy, enter HIGH; PMT[i]=1 and busy[i]=1 from cycle t+1.
REQ-020 Effective values: Pe = max(P,1); He = min(H, Pe-1).
REQ-021 HIGH lasts exactly He+1 cycles; LOW lasts exactly Pe-He cycles; one period is Pe+1 cycles.
REQ-022 Phase counter is CNT_W bits, clears at every phase change, never wraps.
REQ-023 Burst counter (BURST_W) increments at each LOW end; when it reaches N (N≠0), the next state is IDLE with done[i]=1 for one cycle and busy[i]=0 in that same cycle.
REQ-024 N=0: LOW returns to HIGH indefinitely; done never asserts.
REQ-025 stop[i] in HIGH/LOW: IDLE next cycle, PMT[i]=0, busy[i]=0, done[i]=0.
REQ-026 stop[i] and start[i] together in IDLE: stop wins, channel stays IDLE.
REQ-027 start[i] while busy is ignored; start held high at completion restarts after exactly one IDLE cycle.
REQ-028 Channels are fully independent; simultaneous starts give cycle-aligned PMT edges.
REQ-029 PMT[i]=0 whenever the channel is IDLE.

Reset
REQ-030 RST_N=0 at an edge: all FSMs IDLE; PMT, busy, done = 0; counters = 0; config registers P=1, H=0, N=0.
REQ-031 Reset mid-run aborts without a done pulse; start is ignored while RST_N=0.

Structure
REQ-032 Shared package pmt_pkg holds the state encoding (IDLE/HIGH/LOW) and default CNT_W/BURST_W constants.
REQ-033 One sub-module pmt_chan (config registers, FSM, counters for one channel), instantiated CH times by generate; top level only decodes cfg_ch.

Verification
REQ-034 Legacy square wave: P=32767, H=16383, N=0, start ch0 -> PMT[0] high 16384 / low 16384 cycles (≈3.05 kHz).
REQ-035 Burst: P=9, H=2, N=3, start ch1 at t -> PMT[1] high t+1..t+3, t+11..t+13, t+21..t+23; done[1] at t+31; busy[1] low from t+31.
REQ-036 Clamp: P=0, H=5, N=2 -> Pe=1, He=0: PMT toggles 1,0,1,0, then done.
REQ-037 Abort/priority: stop mid-HIGH -> PMT=0 and busy=0 next cycle, no done; start+stop in IDLE -> stays IDLE.
REQ-038 Config during run: rewrite P of running ch2 -> current run unchanged; after restart, new period observed.
REQ-039 Reset mid-run and cfg_ch=CH -> all outputs 0 next cycle; out-of-range write changes no channel.

Source files
------------

// File: rtl/pmt_pkg.sv
// Shared definitions for the PMT pulse generator: channel FSM encoding and
// default field widths.
package pmt_pkg;

  localparam int unsigned PMT_CNT_W   = 14;
  localparam int unsigned PMT_BURST_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pmt_state_e;

endpackage

// File: rtl/pmt_chan.sv
// One PMT pulse channel: config registers, active copy latched at start,
// HIGH/LOW phase FSM with phase and burst counters, registered outputs.
module pmt_chan
  import pmt_pkg::*;
#(
  parameter int unsigned CNT_W   = PMT_CNT_W,
  parameter int unsigned BURST_W = PMT_BURST_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               pmt,
  output logic               busy,
  output logic               done
);

  pmt_state_e         state, state_d;
  logic [CNT_W-1:0]   cfg_p, cfg_h;
  logic [BURST_W-1:0] cfg_n;
  logic [CNT_W-1:0]   act_he, act_lo, he_d, lo_d;
  logic [BURST_W-1:0] act_n, n_d;
  logic [CNT_W-1:0]   phase_cnt, phase_d;
  logic [BURST_W-1:0] burst_cnt, burst_d;
  logic [CNT_W-1:0]   pe_c, he_c, lo_c;
  logic               pmt_d, busy_d, done_d;

  // Effective timing from the stored config; act_lo is the last LOW phase count.
  always_comb begin
    pe_c = (cfg_p == '0) ? CNT_W'(1) : cfg_p;
    he_c = (cfg_h > (pe_c - CNT_W'(1))) ? (pe_c - CNT_W'(1)) : cfg_h;
    lo_c = pe_c - he_c - CNT_W'(1);
  end

  // Next state, counters and output values.
  always_comb begin
    state_d = state;
    phase_d = phase_cnt;
    burst_d = burst_cnt;
    he_d    = act_he;
    lo_d    = act_lo;
    n_d     = act_n;
    done_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_HIGH;
          phase_d = '0;
          burst_d = '0;
          he_d    = he_c;
          lo_d    = lo_c;
          n_d     = cfg_n;
        end
      end
      ST_HIGH: begin
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = '0;
          burst_d = '0;
        end else if (phase_cnt == act_he) begin
          state_d = ST_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_cnt + CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = '0;
          burst_d = '0;
        end else if (phase_cnt == act_lo) begin
          phase_d = '0;
          burst_d = burst_cnt + BURST_W'(1);
          if ((act_n != '0) && (burst_d == act_n)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HIGH;
          end
        end else begin
          phase_d = phase_cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pmt_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      burst_cnt <= '0;
      act_he    <= '0;
      act_lo    <= '0;
      act_n     <= '0;
      cfg_p     <= CNT_W'(1);
      cfg_h     <= '0;
      cfg_n     <= '0;
      pmt       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      phase_cnt <= phase_d;
      burst_cnt <= burst_d;
      act_he    <= he_d;
      act_lo    <= lo_d;
      act_n     <= n_d;
      pmt       <= pmt_d;
      busy      <= busy_d;
      done      <= done_d;
      if (cfg_we) begin
        cfg_p <= cfg_period;
        cfg_h <= cfg_high;
        cfg_n <= cfg_burst;
      end
    end
  end

endmodule

// File: rtl/pmt_pulse_gen.sv
// Multi-channel PMT pulse generator: decodes the config channel address and
// replicates one independent pmt_chan per output.
module pmt_pulse_gen
  import pmt_pkg::*;
#(
  parameter  int unsigned CH      = 4,
  parameter  int unsigned CNT_W   = PMT_CNT_W,
  parameter  int unsigned BURST_W = PMT_BURST_W,
  localparam int unsigned CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [CH-1:0]      start,
  input  logic [CH-1:0]      stop,
  output logic [CH-1:0]      PMT,
  output logic [CH-1:0]      busy,
  output logic [CH-1:0]      done
);

  logic [CH-1:0] cfg_sel;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    // Addresses at or above CH match no channel and are dropped.
    assign cfg_sel[i] = cfg_we && (cfg_ch == CH_W'(i));

    pmt_chan #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_chan (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .cfg_we     (cfg_sel[i]),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_burst  (cfg_burst),
      .start      (start[i]),
      .stop       (stop[i]),
      .pmt        (PMT[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_pmt_pulse_gen.sv
// Scoreboard bench for pmt_pulse_gen: a schedule-based reference model queues
// the expected outputs for every clock edge; a monitor compares them.
module tb_pmt_pulse_gen;

  localparam int unsigned CH      = 3;
  localparam int unsigned CNT_W   = 15;
  localparam int unsigned BURST_W = 16;
  localparam int unsigned CH_W    = 2;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_high;
  logic [BURST_W-1:0] cfg_burst;
  logic [CH-1:0]      start;
  logic [CH-1:0]      stop;
  logic [CH-1:0]      PMT;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      done;

  pmt_pulse_gen #(.CH(CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_burst(cfg_burst),
    .start(start), .stop(stop), .PMT(PMT), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [CH-1:0] pmt;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_edge = 0;

  // Reference model: a run is a start edge plus effective P/H/N; outputs follow
  // from the offset since that edge.
  int m_p[CH], m_h[CH], m_n[CH];
  bit run[CH];
  int t0[CH], a_pe[CH], a_he[CH], a_n[CH];
  int edge_no = 0;

  task automatic model_edge();
    exp_t x;
    int   rel, per;
    x = '0;
    edge_no++;
    if (!RST_N) begin
      for (int i = 0; i < CH; i++) begin
        run[i] = 1'b0; m_p[i] = 1; m_h[i] = 0; m_n[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (run[i]) begin
          if (stop[i]) run[i] = 1'b0;
        end else if (start[i] && !stop[i]) begin
          run[i]  = 1'b1;
          t0[i]   = edge_no;
          a_pe[i] = (m_p[i] == 0) ? 1 : m_p[i];
          a_he[i] = (m_h[i] < a_pe[i]) ? m_h[i] : a_pe[i] - 1;
          a_n[i]  = m_n[i];
        end
      end
      if (cfg_we && (int'(cfg_ch) < CH)) begin
        m_p[cfg_ch] = int'(cfg_period);
        m_h[cfg_ch] = int'(cfg_high);
        m_n[cfg_ch] = int'(cfg_burst);
      end
      for (int i = 0; i < CH; i++) begin
        if (run[i]) begin
          rel = edge_no - t0[i];
          per = a_pe[i] + 1;
          if ((a_n[i] != 0) && (rel == a_n[i] * per)) begin
            x.done[i] = 1'b1;
            run[i]    = 1'b0;
          end else begin
            x.busy[i] = 1'b1;
            x.pmt[i]  = ((rel % per) <= a_he[i]);
          end
        end
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_edge();
      #2;
    end
  endtask

  task automatic cfg(input int ch, input int p, input int h, input int n);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_burst  = BURST_W'(n);
    cyc(1);
    cfg_we     = 1'b0;
  endtask

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d actual %b required %b", name, mon_edge, act, req);
    end
  endtask

  // Monitor: one expected entry per edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_edge++;
        chk("pmt", PMT, e.pmt);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
      end
    end
  end

  initial begin
    RST_N = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_high = '0; cfg_burst = '0;
    start = '1; stop = '0;
    #2;
    cyc(3);
    RST_N = 1'b1; start = '0;
    cyc(2);

    // Burst P=9 H=2 N=3 on ch1.
    cfg(1, 9, 2, 3);
    start[1] = 1'b1; cyc(1); start[1] = 1'b0;
    cyc(40);

    // Clamp P=0 H=5 N=2 on ch0.
    cfg(0, 0, 5, 2);
    start[0] = 1'b1; cyc(1); start[0] = 1'b0;
    cyc(8);

    // Abort mid-HIGH, then start and stop together while idle.
    cfg(0, 20, 10, 0);
    start[0] = 1'b1; cyc(1); start[0] = 1'b0;
    cyc(5);
    stop[0] = 1'b1; cyc(1); stop[0] = 1'b0;
    cyc(2);
    start[0] = 1'b1; stop[0] = 1'b1; cyc(3);
    start[0] = 1'b0; stop[0] = 1'b0; cyc(2);

    // Rewrite ch2 period mid-run, then hold start across completions.
    cfg(2, 6, 3, 2);
    start[2] = 1'b1; cyc(1); start[2] = 1'b0;
    cyc(3);
    cfg(2, 12, 3, 2);
    cyc(20);
    start[2] = 1'b1; cyc(70); start[2] = 1'b0;
    cyc(30);

    // Simultaneous starts with identical config.
    for (int i = 0; i < CH; i++) cfg(i, 5, 1, 2);
    start = '1; cyc(1); start = '0;
    cyc(16);

    // Out-of-range write, restart to expose config, then reset mid-run.
    cfg(3, 2, 1, 1);
    start = '1; cyc(1); start = '0;
    cyc(4);
    RST_N = 1'b0; start = '1; cyc(2);
    RST_N = 1'b1; start = '0; cyc(3);
    start = '1; cyc(1); start = '0;
    cyc(6);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      cfg_we     = ($urandom % 8) == 0;
      cfg_ch     = CH_W'($urandom % 4);
      cfg_period = CNT_W'($urandom % 12);
      cfg_high   = CNT_W'($urandom % 12);
      cfg_burst  = BURST_W'($urandom % 4);
      for (int i = 0; i < CH; i++) begin
        start[i] = ($urandom % 4) == 0;
        stop[i]  = ($urandom % 32) == 0;
      end
      RST_N = ($urandom % 400) != 0;
      cyc(1);
    end
    cfg_we = 1'b0; start = '0; stop = '0; RST_N = 1'b1;
    stop = '1; cyc(1); stop = '0;
    cyc(2);

    // Legacy square wave on ch0: 16384 high / 16384 low.
    cfg(0, 32767, 16383, 0);
    start[0] = 1'b1; cyc(1); start[0] = 1'b0;
    cyc(32768 + 40);
    stop[0] = 1'b1; cyc(1); stop[0] = 1'b0;
    cyc(3);

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
